serial_parity_checker_v: RTL and testbench
==========================================

// Module: serial_parity_checker_v
// PURPOSE
//  Sequential consumer of XOR-based parity: receives a serial frame (DATA_W data bits, then 1 even-parity bit),
//  accumulates running parity through an XOR2_gate_v instance, and reports the deserialised word plus a parity error.
//  Sits downstream of the gate-level XOR datapath; first clocked stage in the datapath-component set.
// PARAMETERS
//  DATA_W     8  data bits per frame, legal 1..32
//  ERR_CNT_W  8  width of saturating error counter (used only when ERR_CNT_EN defined)
// PORTS
//  i_clk      in   1          clock, all state updates on rising edge
//  i_rst_n    in   1          asynchronous, active-low reset
//  i_start    in   1          begin a frame; honoured only in IDLE
//  i_valid    in   1          i_bit is a valid frame bit this cycle
//  i_bit      in   1          serial bit, data LSB first, parity bit last
//  o_busy     out  1          high from the cycle after start accepted until the cycle after DONE
//  o_data     out  DATA_W     last received word; frame bit k -> o_data[k]
//  o_done     out  1          one-cycle pulse: frame complete, o_data/o_par_err valid
//  o_par_err  out  1          1 = (XOR of data bits) ^ parity bit != 0
//  o_err_cnt  out  ERR_CNT_W  frames with parity error (ERR_CNT_EN only)
// BEHAVIOUR
//  Reset (async, i_rst_n=0): state IDLE; all outputs, shift reg, bit counter, accumulator = 0. Effective mid-frame; partial frame discarded, no o_done.
//  FSM (registered state):
//   IDLE  : o_busy=0. i_start=1 -> DATA; bit counter=0, accumulator=0, o_par_err=0; o_data holds old word until first data bit.
//           i_valid in IDLE ignored; i_start with i_valid same cycle: start accepted, that bit discarded.
//   DATA  : each i_valid=1 cycle: shift i_bit into word at position counter, acc <= acc XOR i_bit (via XOR2_gate_v), counter++.
//           i_valid=0: hold everything (gaps of any length). After DATA_W-th valid bit -> PARITY.
//   PARITY: first i_valid=1 cycle: err = acc XOR i_bit; register o_par_err=err, o_data=word; -> DONE.
//   DONE  : o_done=1 for exactly this one cycle; o_busy=1; unconditional -> IDLE.
//  Latency: o_done asserts the cycle after the parity bit is sampled; min frame = DATA_W+3 cycles from start.
//  i_start while not IDLE: ignored, no effect on frame in progress. i_start in DONE cycle ignored; restart next cycle.
//  o_data and o_par_err hold their values until the next completed frame (o_par_err cleared on accepted start).
//  Counter width: ceil(log2(DATA_W+1)) bits; counter never exceeds DATA_W.
// CONFIGURATION
//  Macro ERR_CNT_EN:
//   defined    : o_err_cnt present; +1 on each DONE with o_par_err=1; saturates at 2^ERR_CNT_W-1; cleared only by reset.
//   undefined  : o_err_cnt port and counter logic absent; all other behaviour identical.
// STRUCTURE
//  Shared package/include serial_parity_pkg: state encodings ST_IDLE=2'd0, ST_DATA=2'd1, ST_PARITY=2'd2, ST_DONE=2'd3;
//   counter-width function (clog2). No other shared items.
//  Sub-module: one XOR2_gate_v instance for the accumulate step (i_a=acc, i_b=i_bit, o_f=next acc); existing gate reused as-is.
//  Rest in-module: state register, bit counter, shift register, output registers, optional error counter.
// TESTING
//  1. DATA_W=8, start, bits of 0xA5 LSB first, parity 0 -> o_done pulse 1 cycle, o_data=0xA5, o_par_err=0, o_err_cnt=0.
//  2. Same word, parity 1 -> o_par_err=1, o_err_cnt=1; next good frame 0x3C/parity 0 -> o_par_err=0, o_err_cnt stays 1.
//  3. 0xFF, parity 0, random i_valid gaps (0-5 idle cycles) -> result identical to gapless; o_done exactly once.
//  4. i_start pulsed mid-DATA and in DONE cycle -> ignored; frame 0x01/parity 1 completes, o_par_err=0.
//  5. i_rst_n low after 3 data bits -> immediately o_busy=0, o_data=0, no o_done; following frame 0x80/parity 1 clean.
//  6. ERR_CNT_W=2, ERR_CNT_EN: 5 bad frames -> o_err_cnt 1,2,3,3,3 (saturates); undefined build compiles without port.

Source files
------------

// File: rtl/serial_parity_pkg.sv
// Shared FSM state encoding and bit-counter sizing helper for the serial parity checker.
package serial_parity_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Bits needed to count 0..n inclusive.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/XOR2_gate_v.sv
// Two-input XOR gate from the gate-level datapath library.
module XOR2_gate_v (
    input  logic i_a,
    input  logic i_b,
    output logic o_f
);

    assign o_f = i_a ^ i_b;

endmodule

// File: rtl/serial_parity_checker_v.sv
// Serial frame receiver: DATA_W data bits (LSB first) then one even-parity bit.
// Optional saturating parity-error counter when ERR_CNT_EN is defined.
module serial_parity_checker_v
    import serial_parity_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_valid,
    input  logic              i_bit,
    output logic              o_busy,
    output logic [DATA_W-1:0] o_data,
    output logic              o_done,
    output logic              o_par_err
`ifdef ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] o_err_cnt
`endif
);

    localparam int unsigned CNT_W = cnt_width(DATA_W);

    if (DATA_W < 1 || DATA_W > 32 || ERR_CNT_W < 1) begin : g_bad_param
        $error("serial_parity_checker_v: illegal DATA_W or ERR_CNT_W");
    end

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] word;
    logic              acc;
    logic              acc_next;

    // acc_next doubles as the final parity verdict once the parity bit arrives.
    XOR2_gate_v u_acc_xor (
        .i_a (acc),
        .i_b (i_bit),
        .o_f (acc_next)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            word      <= '0;
            acc       <= 1'b0;
            o_busy    <= 1'b0;
            o_data    <= '0;
            o_done    <= 1'b0;
            o_par_err <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        state     <= ST_DATA;
                        o_busy    <= 1'b1;
                        cnt       <= '0;
                        word      <= '0;
                        acc       <= 1'b0;
                        o_par_err <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (i_valid) begin
                        for (int unsigned k = 0; k < DATA_W; k++) begin
                            if (cnt == CNT_W'(k)) begin
                                word[k] <= i_bit;
                            end
                        end
                        acc <= acc_next;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(DATA_W - 1)) begin
                            state <= ST_PARITY;
                        end
                    end
                end
                ST_PARITY: begin
                    if (i_valid) begin
                        o_par_err <= acc_next;
                        o_data    <= word;
                        o_done    <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    o_busy <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ERR_CNT_EN
    // Counts on the same edge that registers the error, so it is current during o_done.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_err_cnt <= '0;
        end else if (state == ST_PARITY && i_valid && acc_next && o_err_cnt != '1) begin
            o_err_cnt <= o_err_cnt + ERR_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_serial_parity_checker_v.sv
// Scoreboard bench for serial_parity_checker_v (DATA_W=8; ERR_CNT_W=2 when ERR_CNT_EN is defined).
module tb_serial_parity_checker_v;

    localparam int unsigned DW = 8;
`ifdef ERR_CNT_EN
    localparam int unsigned EW      = 2;
    localparam int          CNT_MAX = 3;
`else
    localparam int          CNT_MAX = 1000;
`endif

    typedef struct packed {
        logic [7:0]  data;
        logic        perr;
        logic [31:0] ecnt;
    } exp_t;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic start   = 1'b0;
    logic valid   = 1'b0;
    logic bit_in  = 1'b0;
    logic busy;
    logic done;
    logic par_err;
    logic [DW-1:0] data;
`ifdef ERR_CNT_EN
    logic [EW-1:0] err_cnt;
`endif

    exp_t sb_q[$];
    int   n_cmp     = 0;
    int   n_err     = 0;
    int   model_cnt = 0;
    logic prev_done = 1'b0;

    always #5 clk = ~clk;

    serial_parity_checker_v #(
        .DATA_W    (DW)
`ifdef ERR_CNT_EN
        ,
        .ERR_CNT_W (EW)
`endif
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_start   (start),
        .i_valid   (valid),
        .i_bit     (bit_in),
        .o_busy    (busy),
        .o_data    (data),
        .o_done    (done),
        .o_par_err (par_err)
`ifdef ERR_CNT_EN
        ,
        .o_err_cnt (err_cnt)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per o_done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            chk("done_single_cycle", 32'(prev_done), 32'd0);
            chk("done_expected", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("o_data", 32'(data), 32'(e.data));
                chk("o_par_err", 32'(par_err), 32'(e.perr));
`ifdef ERR_CNT_EN
                chk("o_err_cnt", 32'(err_cnt), e.ecnt);
`endif
            end
        end
        prev_done = done;
    end

    task automatic send_frame(input logic [7:0] w, input logic p, input int max_gap,
                              input bit mid_start, input bit done_start);
        logic [8:0] bits;
        logic       bad;
        bits = {p, w};
        bad  = (^w) ^ p;
        if (bad && model_cnt < CNT_MAX) model_cnt++;
        sb_q.push_back('{data: w, perr: bad, ecnt: 32'(model_cnt)});
        @(posedge clk); #1;
        start = 1'b1;
        valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        for (int k = 0; k < 9; k++) begin
            int gap;
            gap = (max_gap > 0) ? int'($urandom_range(32'(max_gap), 0)) : 0;
            repeat (gap) begin
                valid = 1'b0;
                @(posedge clk); #1;
            end
            valid  = 1'b1;
            bit_in = bits[k];
            start  = mid_start && (k == 3);
            @(posedge clk); #1;
        end
        valid = 1'b0;
        start = done_start;
        chk("busy_in_done", 32'(busy), 32'd1);
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_idle_after_done", 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk("stays_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_par_err", 32'(par_err), 32'd0);
`ifdef ERR_CNT_EN
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
        rst_n = 1'b1;

        send_frame(8'hA5, 1'b0, 0, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b1, 0, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 0, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b0, 5, 1'b0, 1'b0);
        send_frame(8'h01, 1'b1, 0, 1'b1, 1'b1);

        // Abort a frame with reset after three data bits.
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            valid  = 1'b1;
            bit_in = 1'b1;
            @(posedge clk); #1;
        end
        valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_data", 32'(data), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_par_err", 32'(par_err), 32'd0);
`ifdef ERR_CNT_EN
        chk("midrst_err_cnt", 32'(err_cnt), 32'd0);
`endif
        model_cnt = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("midrst_still_idle", 32'(busy), 32'd0);

        send_frame(8'h80, 1'b1, 0, 1'b0, 1'b0);

`ifdef ERR_CNT_EN
        for (int i = 0; i < 5; i++) begin
            send_frame(8'hA5, 1'b1, 0, 1'b0, 1'b0);
        end
`endif

        repeat (5) @(posedge clk);
        #1;
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
